// File: rtl/btn_debounce.sv
// btn_debounce: synchronises and debounces a raw push-button input.
// It outputs a clean level and one-cycle press, release and long-press pulses.
//
// Timing (cycles derived from clock frequency):
//   DB = FREQ/1000*DEBOUNCE_MS  stable cycles needed to accept a level change
//   LG = FREQ/1000*LONG_MS      held cycles for a long press (LONG_MS = 0 disables)
//
// Ports:
//   clk_i      system clock
//   rst_i      synchronous active-high reset
//   btn_i      raw asynchronous button, active-high
//   level_o    debounced level
//   press_o    one-cycle pulse on accepted press
//   release_o  one-cycle pulse on accepted release
//   long_o     one-cycle pulse once per press after LG held cycles
//   count_o    press counter (mod 256) when BTN_PRESS_COUNT_EN is defined, else 0
//
// Optional feature macro: BTN_PRESS_COUNT_EN
//
// Pulses and level are decoded from registered state plus the synchronised
// input. Press therefore appears DB+2 edges after btn_i is first sampled high.
module btn_debounce #(
    parameter int FREQ        = 50000000,
    parameter int DEBOUNCE_MS = 10,
    parameter int LONG_MS     = 1000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       btn_i,
    output logic       level_o,
    output logic       press_o,
    output logic       release_o,
    output logic       long_o,
    output logic [7:0] count_o
);

    localparam int DB      = FREQ / 1000 * DEBOUNCE_MS;
    localparam int LG      = FREQ / 1000 * LONG_MS;
    localparam bit LONG_EN = (LONG_MS != 0);
    localparam int MAX_CNT = (DB > LG) ? DB : LG;
    localparam int CW      = (MAX_CNT < 1) ? 1 : $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] DB_C    = CW'(DB);
    localparam logic [CW-1:0] LG_C    = CW'(LG);
    localparam logic [CW-1:0] LG_M1   = CW'((LG > 0) ? LG - 1 : 0);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    if (DB < 1) begin : g_bad_db
        $error("btn_debounce: debounce time must be at least one cycle");
    end
    if (LONG_MS != 0 && LG < 1) begin : g_bad_lg
        $error("btn_debounce: long-press time must be at least one cycle");
    end

    localparam logic [2:0] StIdle       = 3'd0;
    localparam logic [2:0] StDebPress   = 3'd1;
    localparam logic [2:0] StPressed    = 3'd2;
    localparam logic [2:0] StLongHeld   = 3'd3;
    localparam logic [2:0] StDebRelease = 3'd4;

    logic          s0_q, s1_q;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] hold_q, hold_d;
    logic          long_done_q, long_done_d;
    logic          press, release_p, long_p;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        long_done_d = long_done_q;
        press       = 1'b0;
        release_p   = 1'b0;
        long_p      = 1'b0;
        case (state_q)
            StIdle: begin
                if (s1_q) begin
                    state_d = StDebPress;
                    cnt_d   = CNT_ONE;
                end
            end
            StDebPress: begin
                if (!s1_q) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == DB_C) begin
                    state_d     = StPressed;
                    press       = 1'b1;
                    cnt_d       = '0;
                    hold_d      = '0;
                    long_done_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            StPressed: begin
                // Hold advances every cycle here, even on the cycle s1 drops,
                // and saturates at LG so it can never wrap.
                if (LONG_EN && hold_q < LG_C) begin
                    hold_d = hold_q + CNT_ONE;
                end
                if (!s1_q) begin
                    state_d = StDebRelease;
                    cnt_d   = CNT_ONE;
                end else if (LONG_EN && hold_q >= LG_M1) begin
                    state_d     = StLongHeld;
                    long_p      = 1'b1;
                    long_done_d = 1'b1;
                end
            end
            StLongHeld: begin
                if (!s1_q) begin
                    state_d = StDebRelease;
                    cnt_d   = CNT_ONE;
                end
            end
            StDebRelease: begin
                // A short drop resumes the press where it left off.
                if (s1_q) begin
                    state_d = long_done_q ? StLongHeld : StPressed;
                    cnt_d   = '0;
                end else if (cnt_q == DB_C) begin
                    state_d   = StIdle;
                    release_p = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s0_q        <= 1'b0;
            s1_q        <= 1'b0;
            state_q     <= StIdle;
            cnt_q       <= '0;
            hold_q      <= '0;
            long_done_q <= 1'b0;
        end else begin
            s0_q        <= btn_i;
            s1_q        <= s0_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            long_done_q <= long_done_d;
        end
    end

    assign press_o   = press;
    assign release_o = release_p;
    assign long_o    = long_p;
    assign level_o   = press ||
                       ((state_q inside {StPressed, StLongHeld, StDebRelease}) && !release_p);

`ifdef BTN_PRESS_COUNT_EN
    logic [7:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= 8'd0;
        end else if (press) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign count_o = count_q;
`else
    assign count_o = 8'd0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: randomized and directed button waveforms checked every
// cycle against a history-based reference model. A second instance with long
// detection disabled shares the same button.
module tb_btn_debounce;

    localparam int DB = 4;
    localparam int LG = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn;
    logic       level, press, rel, lng;
    logic [7:0] count;
    logic       level_nl, press_nl, rel_nl, lng_nl;
    logic [7:0] count_nl;

    always #5 clk = ~clk;

    btn_debounce #(.FREQ(1000), .DEBOUNCE_MS(4), .LONG_MS(20)) u_dut (
        .clk_i(clk), .rst_i(rst), .btn_i(btn), .level_o(level), .press_o(press),
        .release_o(rel), .long_o(lng), .count_o(count)
    );

    btn_debounce #(.FREQ(1000), .DEBOUNCE_MS(4), .LONG_MS(0)) u_dut_nl (
        .clk_i(clk), .rst_i(rst), .btn_i(btn), .level_o(level_nl), .press_o(press_nl),
        .release_o(rel_nl), .long_o(lng_nl), .count_o(count_nl)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int step_no = 0;

    // Model: s1 is the input delayed two samples; a level flips once the new
    // value has been seen DB+1 consecutive cycles. Hold time accrues in cycles
    // where the button was accepted as pressed and was high on the previous cycle.
    int m_s0, m_s1, m_prev, m_run, m_level, m_hold, m_ld, m_cnt;
    int e_press, e_rel, e_long, e_level, e_cnt;

    // Event log built from observed outputs for directed latency checks.
    int n_press, n_rel, n_long, press_step, rel_step, long_step;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s step=%0d got=%0d expected=%0d", tag, step_no, got, exp);
        end
    endtask

    task automatic clr_ev();
        n_press = 0; n_rel = 0; n_long = 0;
        press_step = -1000; rel_step = -1000; long_step = -1000;
    endtask

    task automatic step(input logic b, input logic r);
        btn = b;
        rst = r;
        @(posedge clk);
        #1;
        step_no++;
        if (r) begin
            m_s0 = 0; m_s1 = 0; m_prev = 0; m_run = 0;
            m_level = 0; m_hold = 0; m_ld = 0; m_cnt = 0;
            e_press = 0; e_rel = 0; e_long = 0; e_level = 0; e_cnt = 0;
        end else begin
            m_s1 = m_s0;
            m_s0 = int'(b);
            m_run = (m_s1 == m_prev) ? m_run + 1 : 1;
            e_press = (m_level == 0 && m_s1 == 1 && m_run == DB + 1) ? 1 : 0;
            e_rel   = (m_level == 1 && m_s1 == 0 && m_run == DB + 1) ? 1 : 0;
            e_long  = (m_level == 1 && m_prev == 1 && m_s1 == 1 && m_ld == 0 &&
                       m_hold >= LG - 1) ? 1 : 0;
            e_level = (e_press == 1) ? 1 : (e_rel == 1) ? 0 : m_level;
`ifdef BTN_PRESS_COUNT_EN
            e_cnt = m_cnt;
`else
            e_cnt = 0;
`endif
            if (m_level == 1 && m_prev == 1 && m_ld == 0 && m_hold < LG) m_hold++;
            if (e_long == 1) m_ld = 1;
            if (e_press == 1) begin
                m_hold = 0;
                m_ld = 0;
                m_cnt = (m_cnt + 1) % 256;
            end
            m_level = e_level;
            m_prev = m_s1;
        end
        chk("level", 32'(level), 32'(e_level));
        chk("press", 32'(press), 32'(e_press));
        chk("release", 32'(rel), 32'(e_rel));
        chk("long", 32'(lng), 32'(e_long));
        chk("count", 32'(count), 32'(e_cnt));
        chk("nl_level", 32'(level_nl), 32'(e_level));
        chk("nl_press", 32'(press_nl), 32'(e_press));
        chk("nl_release", 32'(rel_nl), 32'(e_rel));
        chk("nl_long", 32'(lng_nl), 32'd0);
        chk("nl_count", 32'(count_nl), 32'(e_cnt));
        if (press === 1'b1) begin n_press++; press_step = step_no; end
        if (rel === 1'b1) begin n_rel++; rel_step = step_no; end
        if (lng === 1'b1) begin n_long++; long_step = step_no; end
    endtask

    int first_step;
    int t0;
    int rst_step;
    logic b;
    int len;

    initial begin
        btn = 1'b0;
        rst = 1'b1;
        clr_ev();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);

        // Clean press held 40 cycles, then release.
        clr_ev();
        step(1'b1, 1'b0);
        first_step = step_no;
        repeat (39) step(1'b1, 1'b0);
        chk("clean_press_lat", 32'(press_step - first_step), 32'(DB + 1));
        chk("clean_long_lat", 32'(long_step - press_step), 32'(LG));
        chk("clean_long_once", 32'(n_long), 32'd1);
        step(1'b0, 1'b0);
        t0 = step_no;
        repeat (11) step(1'b0, 1'b0);
        chk("clean_rel_lat", 32'(rel_step - t0), 32'(DB + 1));
        chk("clean_press_once", 32'(n_press), 32'd1);
        chk("clean_rel_once", 32'(n_rel), 32'd1);

        // Bounce 1,0,1,0,1 then steady high.
        clr_ev();
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        t0 = step_no;
        repeat (12) step(1'b1, 1'b0);
        chk("bounce_press_lat", 32'(press_step - t0), 32'(DB + 1));
        chk("bounce_press_once", 32'(n_press), 32'd1);
        repeat (12) step(1'b0, 1'b0);

        // Short release glitch mid-hold: long pulse shifts by the frozen cycles.
        clr_ev();
        repeat (16) step(1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0);
        repeat (30) step(1'b1, 1'b0);
        chk("glitch_no_release", 32'(n_rel), 32'd0);
        chk("glitch_press_once", 32'(n_press), 32'd1);
        chk("glitch_long_lat", 32'(long_step - press_step), 32'(LG + 2));
        repeat (12) step(1'b0, 1'b0);

        // Reset while pressed: no release, re-press after reset.
        clr_ev();
        repeat (10) step(1'b1, 1'b0);
        chk("pre_rst_level", 32'(level), 32'd1);
        step(1'b1, 1'b1);
        rst_step = step_no;
        chk("rst_level", 32'(level), 32'd0);
        clr_ev();
        repeat (10) step(1'b1, 1'b0);
        chk("rst_repress_lat", 32'(press_step - rst_step), 32'(DB + 2));
        chk("rst_no_release", 32'(n_rel), 32'd0);
        repeat (12) step(1'b0, 1'b0);

        // Randomized runs with occasional resets.
        for (int i = 0; i < 80; i++) begin
            b = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 30));
            repeat (len) step(b, 1'b0);
            if ($urandom_range(0, 19) == 0) step(b, 1'b1);
        end

        // 257 clean presses from reset.
        step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        clr_ev();
        repeat (257) begin
            repeat (8) step(1'b1, 1'b0);
            repeat (8) step(1'b0, 1'b0);
        end
        chk("presses_257", 32'(n_press), 32'd257);
`ifdef BTN_PRESS_COUNT_EN
        chk("count_257", 32'(count), 32'd1);
`else
        chk("count_257", 32'(count), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Input-side counterpart to the LED blink output path. Takes a raw, asynchronous, bouncing push-button input.
- Synchronises and debounces it, then emits a clean level plus one-cycle press, release and long-press pulses.
- Sits between a board button pin and user logic in the example designs. Uses the same FREQ-based timing style as the blink generator.

Parameters:
- FREQ, 50000000, clock frequency in Hz.
- DEBOUNCE_MS, 10, required stable time in ms. DB = FREQ/1000*DEBOUNCE_MS cycles.
- LONG_MS, 1000, hold time for a long press in ms. LG = FREQ/1000*LONG_MS cycles. LONG_MS = 0 disables long detection.

Ports:
- clk_i  in  1  single system clock
- rst_i  in  1  synchronous, active-high reset
- btn_i  in  1  raw button, asynchronous, active-high
- level_o  out  1  debounced button level
- press_o  out  1  one-cycle pulse on debounced press
- release_o  out  1  one-cycle pulse on debounced release
- long_o  out  1  one-cycle pulse when held for LG cycles
- count_o  out  8  press counter (see Optional Feature)

Behaviour:
- Elaboration: DB < 1 → $error. LONG_MS != 0 and LG < 1 → $error.
- Reset, sampled on the clk_i rising edge while rst_i = 1:
  - state IDLE; sync flops 0; counters 0; long_done 0.
  - All outputs 0, including count_o.
- Synchroniser: two flops, s0 then s1. Only s1 is used downstream.
- Timing: btn_i first sampled high at edge E0 → s1 = 1 after E1. s1 = 1 stable → press_o high for exactly the cycle after edge E1+DB. Press latency = DB+2 edges.
- State machine:
  - IDLE: s1 = 1 → DEB_PRESS, cnt = 1.
  - DEB_PRESS:
    - s1 = 0 → IDLE (bounce, counter cleared).
    - s1 = 1 and cnt = DB → PRESSED; assert press_o; level_o = 1; hold = 0; long_done = 0.
    - otherwise cnt++.
  - PRESSED:
    - hold++ each cycle.
    - If LONG enabled and hold reaches LG: assert long_o, long_done = 1, go to LONG_HELD.
    - s1 = 0 → DEB_RELEASE, cnt = 1. Release takes priority over long in the same cycle.
  - LONG_HELD: s1 = 0 → DEB_RELEASE, cnt = 1. hold is frozen.
  - DEB_RELEASE:
    - s1 = 1 → back to PRESSED if long_done = 0, else LONG_HELD. hold resumes without clearing. No extra press_o.
    - s1 = 0 and cnt = DB → IDLE; assert release_o; level_o = 0.
    - otherwise cnt++.
- level_o changes only in the same cycle as press_o or release_o.
- Pulses are never simultaneous. long_o fires at most once per press.
- Counter widths are sized by $clog2 of max(DB, LG) + 1. No wrap is possible within one press.
- Reset mid-operation: returns to IDLE immediately, with no release_o. If the button is still held, it is treated as a new press after DB+2 cycles.

Optional Feature:
- Macro: BTN_PRESS_COUNT_EN.
- Defined: count_o increments by 1 (mod 256) in the same cycle as press_o, so the new value is visible the cycle after the pulse. 255 wraps to 0. Reset clears it to 0.
- Undefined: no counter logic is built; count_o is tied to 8'd0.

Test Plan:
- Use FREQ = 1000, DEBOUNCE_MS = 4, LONG_MS = 20, so DB = 4 and LG = 20.
- Clean press: btn_i 0→1 held 40 cycles → press_o pulse 6 edges after first sample; level_o = 1; long_o exactly once, 20 cycles after press_o; then btn_i 0 → release_o after 6 cycles; level_o = 0.
- Bounce: btn_i toggles 1,0,1,0,1 (one cycle each) then stays 1 → no pulse during bouncing; a single press_o, 6 cycles after the final rise.
- Short release glitch: held button drops to 0 for 2 cycles at hold = 10 → no release_o and no extra press_o; long_o appears at total hold = 20 with frozen-count offset (2 cycles later than unglitched).
- Reset mid-press: rst_i = 1 for 1 cycle while level_o = 1 → all outputs 0 next cycle, no release_o; btn still high → new press_o 6 cycles after reset deasserts.
- Counter (macro defined): 257 clean presses → count_o = 1. Macro undefined → count_o = 0 throughout.
- LONG_MS = 0: hold 100 cycles → long_o never asserted; press_o and release_o are normal.
